pc_stack: RTL

Parametrised program counter for the SAP datapath with a hardware return-address stack (LIFO) and signed relative branching. It replaces the plain inc/load program counter and keeps its behaviour when the new controls are tied low. It sits between the control sequencer, which drives the one-hot-ish control strobes, and the memory address register, which consumes `q`.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/ret_stack.sv | 59 +++++
 rtl/pc_stack.sv | 79 +++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program counter: operation enum and strobe decoder.
// pc_decode maps the raw control strobes onto one operation by priority.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_REL,
    OP_LOAD,
    OP_RET,
    OP_CALL
  } pc_op_e;

  // Strobes may overlap; the first one set in this order wins.
  function automatic pc_op_e pc_decode(
    input logic call,
    input logic ret,
    input logic load,
    input logic rel,
    input logic inc
  );
    pc_op_e op;
    if (call)      op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (load) op = OP_LOAD;
    else if (rel)  op = OP_REL;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop with occupancy, full/empty and
// single-cycle overflow (push while full) / underflow (pop while empty) pulses.
module ret_stack #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);
  import pc_pkg::*;

  logic [N-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // push outranks pop so a simultaneous pair never pops
  assign do_push = push && !full;
  assign do_pop  = pop && !push && !empty;
  assign ovf     = push && full;
  assign unf     = pop && !push && empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        level <= level + LW'(1);
        for (int i = 0; i < DEPTH; i++)
          if (level == LW'(i))
            mem[i] <= din;
      end else if (do_pop) begin
        level <= level - LW'(1);
      end
    end
  end

  // entry at level-1 is the top; zero when empty
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (level == LW'(i + 1))
        top = mem[i];
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with return-address stack and signed relative branch.
// Ports: clk, reset(n), inc/load/rel/call/ret strobes, d; q, level, full, empty, err_ovf, err_unf.
module pc_stack #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic          rel,
  input  logic          call,
  input  logic          ret,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          err_ovf,
  output logic          err_unf
);
  import pc_pkg::*;

  pc_op_e       op;
  logic [N-1:0] q_inc;
  logic [N-1:0] q_rel;
  logic [N-1:0] q_nxt;
  logic [N-1:0] top;
  logic         ovf;
  logic         unf;

  assign op    = pc_decode(call, ret, load, rel, inc);
  assign q_inc = q + N'(1);
  // two's complement add; truncation gives wrap both ways
  assign q_rel = q + d;

  ret_stack #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (op == OP_CALL),
    .pop   (op == OP_RET),
    .din   (q_inc),
    .top   (top),
    .level (level),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  always_comb begin
    q_nxt = q;
    unique case (op)
      OP_INC:  q_nxt = q_inc;
      OP_REL:  q_nxt = q_rel;
      OP_LOAD: q_nxt = d;
      OP_CALL: if (!full)  q_nxt = d;
      OP_RET:  if (!empty) q_nxt = top;
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      q <= q_nxt;
      if (ovf) err_ovf <= 1'b1;
      if (unf) err_unf <= 1'b1;
    end
  end

endmodule
